// File: rtl/edge_ctrl_pkg.sv
// Shared types and constants for the Sobel engine memory sequencer.
package edge_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_RESP = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    localparam logic [1:0] ED_MODE_IDLE  = 2'b00;
    localparam logic [1:0] ED_MODE_FILL  = 2'b01;
    localparam logic [1:0] ED_MODE_WRITE = 2'b10;

    localparam logic [3:0] FULL_BEATS  = 4'd12;
    localparam logic [3:0] REUSE_BEATS = 4'd6;
    localparam logic [3:0] WR_BEATS    = 4'd2;

    // First column fetched when the two left columns are recycled.
    localparam logic [1:0] REUSE_COL = 2'd2;

    // Window byte slot: row*4 + col.
    function automatic logic [3:0] slot_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/edge_addr_gen.sv
// Beat sequencer: beat/row/col counters and a running row-base adder that
// produce the registered memory byte address and the window slot of the current beat.
module edge_addr_gen
    import edge_ctrl_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int PIX_W  = 20
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load_rd_i,
    input  logic              load_wr_i,
    input  logic              advance_i,
    input  logic              reuse_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [PIX_W-1:0]  rpixnum_i,
    input  logic [PIX_W-1:0]  wpixnum_i,
    input  logic [11:0]       image_width_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        slot_o,
    output logic              first_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        col_start_q, col_start_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        beat_q, beat_d;
    logic [3:0]        beats_q, beats_d;

    // Next counter/address values for a sequence start or an acked beat.
    always_comb begin
        row_base_d  = row_base_q;
        addr_d      = addr_q;
        col_d       = col_q;
        col_start_d = col_start_q;
        row_d       = row_q;
        beat_d      = beat_q;
        beats_d     = beats_q;
        if (load_rd_i) begin
            col_start_d = reuse_i ? REUSE_COL : 2'd0;
            row_base_d  = src_base_i + ADDR_W'(rpixnum_i);
            col_d       = col_start_d;
            row_d       = 2'd0;
            beat_d      = 4'd0;
            beats_d     = reuse_i ? REUSE_BEATS : FULL_BEATS;
            addr_d      = row_base_d + ADDR_W'(col_d);
        end else if (load_wr_i) begin
            col_start_d = 2'd0;
            row_base_d  = dst_base_i + ADDR_W'(wpixnum_i);
            col_d       = 2'd0;
            row_d       = 2'd0;
            beat_d      = 4'd0;
            beats_d     = WR_BEATS;
            addr_d      = row_base_d;
        end else if (advance_i) begin
            beat_d = beat_q + 4'd1;
            // Row wrap: add one row length instead of multiplying.
            if (col_q == 2'd3) begin
                col_d      = col_start_q;
                row_d      = row_q + 2'd1;
                row_base_d = row_base_q + ADDR_W'(image_width_i);
            end else begin
                col_d = col_q + 2'd1;
            end
            addr_d = row_base_d + ADDR_W'(col_d);
        end else begin
            addr_d = addr_q;
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_base_q  <= '0;
            addr_q      <= '0;
            col_q       <= 2'd0;
            col_start_q <= 2'd0;
            row_q       <= 2'd0;
            beat_q      <= 4'd0;
            beats_q     <= 4'd0;
        end else begin
            row_base_q  <= row_base_d;
            addr_q      <= addr_d;
            col_q       <= col_d;
            col_start_q <= col_start_d;
            row_q       <= row_d;
            beat_q      <= beat_d;
            beats_q     <= beats_d;
        end
    end

    assign addr_o  = addr_q;
    assign slot_o  = slot_idx(row_q, col_q);
    assign first_o = (beat_q == 4'd0);
    assign last_o  = (beat_q == beats_q - 4'd1);

endmodule

// File: rtl/edge_mem_ctrl.sv
// Sobel engine memory sequencer: 3x4 window fetch and 2-pixel write over a byte SRAM port.
// Optional column reuse between horizontally adjacent fills: EDGE_COL_REUSE_EN.
module edge_mem_ctrl
    import edge_ctrl_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int PIX_W  = 20
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ed_start,
    input  logic [1:0]        ed_mode,
    input  logic              fill_buff,
    input  logic [PIX_W-1:0]  rpixnum,
    input  logic [PIX_W-1:0]  wpixnum,
    input  logic [15:0]       wdata,
    input  logic [11:0]       image_width,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              buff_filled,
    output logic [95:0]       rdata,
    output logic              dfb,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  wdata_hi_q, wdata_hi_d;
    logic [95:0] rdata_q, rdata_d;
    logic        buff_filled_q, buff_filled_d;
    logic        dfb_q, dfb_d;
    logic        load_rd_s, load_wr_s, advance_s, ack_s;
    logic        reuse_hit_s, reuse_fill_s;
    logic [3:0]  slot_s;
    logic        first_s, last_s;

    edge_addr_gen #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) u_addr_gen (
        .clk           (clk),
        .n_rst         (n_rst),
        .load_rd_i     (load_rd_s),
        .load_wr_i     (load_wr_s),
        .advance_i     (advance_s),
        .reuse_i       (reuse_hit_s),
        .src_base_i    (src_base),
        .dst_base_i    (dst_base),
        .rpixnum_i     (rpixnum),
        .wpixnum_i     (wpixnum),
        .image_width_i (image_width),
        .addr_o        (mem_addr),
        .slot_o        (slot_s),
        .first_o       (first_s),
        .last_o        (last_s)
    );

    assign ack_s = mem_req_q && mem_ack;

    // Sequencer next state, handshake outputs and window capture.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_wdata_d   = mem_wdata_q;
        wdata_hi_d    = wdata_hi_q;
        rdata_d       = rdata_q;
        buff_filled_d = 1'b0;
        dfb_d         = 1'b0;
        load_rd_s     = 1'b0;
        load_wr_s     = 1'b0;
        advance_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ed_mode == ED_MODE_FILL && fill_buff) begin
                    state_d   = ST_RD;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                    load_rd_s = 1'b1;
                end else if (ed_mode == ED_MODE_WRITE) begin
                    state_d     = ST_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = wdata[7:0];
                    wdata_hi_d  = wdata[15:8];
                    load_wr_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (ack_s) begin
                    // Left columns are recycled only once new data starts arriving.
                    if (first_s && reuse_fill_s) begin
                        for (int r = 0; r < 3; r++) begin
                            rdata_d[r*32 +: 16] = rdata_q[r*32+16 +: 16];
                        end
                    end else begin
                        rdata_d = rdata_q;
                    end
                    rdata_d[{slot_s, 3'b000} +: 8] = mem_rdata;
                    if (last_s) begin
                        state_d       = ST_RESP;
                        mem_req_d     = 1'b0;
                        buff_filled_d = 1'b1;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                if (ack_s) begin
                    if (last_s) begin
                        state_d   = ST_RESP;
                        mem_req_d = 1'b0;
                        dfb_d     = 1'b1;
                    end else begin
                        advance_s   = 1'b1;
                        mem_wdata_d = wdata_hi_q;
                    end
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RESP: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (ed_mode == ED_MODE_IDLE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= 8'h00;
            wdata_hi_q    <= 8'h00;
            rdata_q       <= '0;
            buff_filled_q <= 1'b0;
            dfb_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            wdata_hi_q    <= wdata_hi_d;
            rdata_q       <= rdata_d;
            buff_filled_q <= buff_filled_d;
            dfb_q         <= dfb_d;
        end
    end

`ifdef EDGE_COL_REUSE_EN
    logic [PIX_W-1:0] last_pix_q, last_pix_d;
    logic             reuse_vld_q, reuse_vld_d;
    logic             reuse_fill_q, reuse_fill_d;

    assign reuse_hit_s  = reuse_vld_q && (rpixnum == last_pix_q + {{(PIX_W-2){1'b0}}, 2'b10});
    assign reuse_fill_s = reuse_fill_q;

    // Last filled index and validity; ed_start low always wins over a completing fill.
    always_comb begin
        last_pix_d   = last_pix_q;
        reuse_fill_d = reuse_fill_q;
        reuse_vld_d  = reuse_vld_q;
        if (load_rd_s) begin
            last_pix_d   = rpixnum;
            reuse_fill_d = reuse_hit_s;
        end else begin
            last_pix_d = last_pix_q;
        end
        if (!ed_start) begin
            reuse_vld_d = 1'b0;
        end else if (buff_filled_d) begin
            reuse_vld_d = 1'b1;
        end else begin
            reuse_vld_d = reuse_vld_q;
        end
    end

    // Reuse tracking registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_pix_q   <= '0;
            reuse_vld_q  <= 1'b0;
            reuse_fill_q <= 1'b0;
        end else begin
            last_pix_q   <= last_pix_d;
            reuse_vld_q  <= reuse_vld_d;
            reuse_fill_q <= reuse_fill_d;
        end
    end
`else
    logic unused_start_s;

    assign reuse_hit_s    = 1'b0;
    assign reuse_fill_s   = 1'b0;
    assign unused_start_s = ed_start;
`endif

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign rdata       = rdata_q;
    assign buff_filled = buff_filled_q;
    assign dfb         = dfb_q;

endmodule

// File: tb/tb_edge_mem_ctrl.sv
// Self-checking bench for edge_mem_ctrl: memory/ack model, expected-beat queue and window model.
module tb_edge_mem_ctrl;
    localparam int AW = 24;
    localparam int PW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_rst, ed_start, fill_buff;
    logic [1:0]    ed_mode;
    logic [PW-1:0] rpixnum, wpixnum;
    logic [15:0]   wdata;
    logic [11:0]   image_width;
    logic [AW-1:0] src_base, dst_base;
    logic          buff_filled, dfb, mem_req, mem_we;
    logic [95:0]   rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;
    logic          mem_ack = 1'b0;

    edge_mem_ctrl #(.ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk), .n_rst(n_rst), .ed_start(ed_start), .ed_mode(ed_mode),
        .fill_buff(fill_buff), .rpixnum(rpixnum), .wpixnum(wpixnum), .wdata(wdata),
        .image_width(image_width), .src_base(src_base), .dst_base(dst_base),
        .buff_filled(buff_filled), .rdata(rdata), .dfb(dfb), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-1:0] wr_addr[$];
    logic [7:0]    wr_data[$];
    int pass_cnt = 0, total_cnt = 0, cyc = 0, ack_wait = 0, wait_cnt = 0;
    int n_beats = 0, n_bf = 0, n_dfb = 0, bf_cyc = 0, dfb_cyc = 0;
    int b0 = 0, req_edge = 0, lat = 0, beats = 0, pulses = 0;
    logic        pend_bf = 1'b0, pend_dfb = 1'b0, win_valid = 1'b1;
    logic [95:0] cur_win = '0, exp_win = '0;
    logic        m_valid = 1'b0;
    logic [PW-1:0] m_last = '0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory/ack model and per-cycle comparison against the expected beat stream.
    always @(negedge clk) begin
        if (!n_rst) begin
            exp_q.delete();
            pend_bf = 1'b0; pend_dfb = 1'b0;
            cur_win = '0; win_valid = 1'b1;
            wait_cnt = 0; mem_ack = 1'b0; mem_rdata = 8'h00;
        end else begin
            chk("buff_filled", buff_filled, pend_bf);
            chk("dfb", dfb, pend_dfb);
            if (pend_bf) begin cur_win = exp_win; win_valid = 1'b1; n_bf++; bf_cyc = cyc; end
            if (pend_dfb) begin n_dfb++; dfb_cyc = cyc; end
            if (win_valid) chk("rdata", rdata, cur_win);
            pend_bf = 1'b0; pend_dfb = 1'b0; mem_ack = 1'b0;
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", mem_req, 1'b0);
                end else begin
                    chk("mem_we", mem_we, exp_q[0].we);
                    chk("mem_addr", mem_addr, exp_q[0].addr);
                    if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].data);
                    if (wait_cnt >= ack_wait) begin
                        mem_ack = 1'b1;
                        mem_rdata = mem_addr[7:0];
                        wait_cnt = 0;
                        n_beats++;
                        if (mem_we) begin
                            wr_addr.push_back(mem_addr);
                            wr_data.push_back(mem_wdata);
                        end else begin
                            win_valid = 1'b0;
                        end
                        if (exp_q.size() == 1) begin
                            if (exp_q[0].we) pend_dfb = 1'b1;
                            else pend_bf = 1'b1;
                        end
                        void'(exp_q.pop_front());
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    task automatic fill_start(input logic [PW-1:0] rpix, input int w);
        logic reuse;
        logic [AW-1:0] a;
        beat_t b;
        @(negedge clk);
        ack_wait = w;
        reuse = 1'b0;
`ifdef EDGE_COL_REUSE_EN
        reuse = m_valid && (rpix == m_last + 20'd2);
`endif
        m_last = rpix;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                a = src_base + AW'(rpix) + AW'(r * image_width) + AW'(c);
                exp_win[(r*4+c)*8 +: 8] = a[7:0];
                if (!reuse || c >= 2) begin
                    b.we = 1'b0; b.addr = a; b.data = 8'h00;
                    exp_q.push_back(b);
                end
            end
        end
        b0 = n_beats;
        req_edge = cyc + 1;
        rpixnum = rpix; ed_mode = 2'b01; fill_buff = 1'b1;
    endtask

    task automatic fill_finish(input int bf0);
        for (int i = 0; i < 400 && n_bf == bf0; i++) @(negedge clk);
        if (n_bf == bf0) chk("fill_timeout", 1'b0, 1'b1);
        lat = bf_cyc - req_edge;
        beats = n_beats - b0;
        ed_mode = 2'b00; fill_buff = 1'b0;
        m_valid = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_fill(input logic [PW-1:0] rpix, input int w);
        int bf0;
        bf0 = n_bf;
        fill_start(rpix, w);
        fill_finish(bf0);
    endtask

    task automatic do_write(input logic [PW-1:0] wpix, input logic [15:0] wd, input int hold);
        int d0;
        beat_t b;
        @(negedge clk);
        ack_wait = 0;
        b.we = 1'b1; b.addr = dst_base + AW'(wpix); b.data = wd[7:0];
        exp_q.push_back(b);
        b.addr = b.addr + 24'd1; b.data = wd[15:8];
        exp_q.push_back(b);
        d0 = n_dfb; b0 = n_beats; req_edge = cyc + 1;
        wpixnum = wpix; wdata = wd; ed_mode = 2'b10;
        @(negedge clk);
        wpixnum = wpix + 20'd7; wdata = ~wd;
        for (int i = 0; i < 400 && n_dfb == d0; i++) @(negedge clk);
        if (n_dfb == d0) chk("write_timeout", 1'b0, 1'b1);
        repeat (hold) @(negedge clk);
        lat = dfb_cyc - req_edge;
        beats = n_beats - b0;
        pulses = n_dfb - d0;
        ed_mode = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int w0, bf0;
        n_rst = 1'b0; ed_start = 1'b1; ed_mode = 2'b00; fill_buff = 1'b0;
        rpixnum = '0; wpixnum = '0; wdata = 16'h0000; image_width = 12'd8;
        src_base = 24'h000100; dst_base = 24'h004000;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 24'h0);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_rdata", rdata, 96'h0);
        chk("rst_buff_filled", buff_filled, 1'b0);
        chk("rst_dfb", dfb, 1'b0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        do_fill(20'd0, 0);
        chk("fill0_lat", lat, 12);
        chk("fill0_beats", beats, 12);
        chk("fill0_byte0", rdata[7:0], 8'h00);
        chk("fill0_byte5", rdata[47:40], 8'h09);
        chk("fill0_byte11", rdata[95:88], 8'h13);

        do_fill(20'd2, 0);
`ifdef EDGE_COL_REUSE_EN
        chk("fill2_lat", lat, 6);
        chk("fill2_beats", beats, 6);
`else
        chk("fill2_lat", lat, 12);
        chk("fill2_beats", beats, 12);
`endif
        chk("fill2_byte0", rdata[7:0], 8'h02);
        chk("fill2_byte11", rdata[95:88], 8'h15);

        do_fill(20'd6, 0);
        chk("fill6_beats", beats, 12);

        ed_start = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        ed_start = 1'b1;
        do_fill(20'd8, 0);
        chk("fill_after_stop_beats", beats, 12);

        do_fill(20'd20, 2);
        chk("wait_fill_lat", lat, 36);
        chk("wait_fill_beats", beats, 12);
        chk("wait_fill_byte11", rdata[95:88], 8'h27);

        w0 = wr_addr.size();
        do_write(20'd5, 16'hA532, 10);
        chk("write_lat", lat, 2);
        chk("write_beats", beats, 2);
        chk("write_pulses", pulses, 1);
        if (wr_addr.size() >= w0 + 2) begin
            chk("write0_addr", wr_addr[w0], 24'h004005);
            chk("write0_data", wr_data[w0], 8'h32);
            chk("write1_addr", wr_addr[w0+1], 24'h004006);
            chk("write1_data", wr_data[w0+1], 8'hA5);
        end else begin
            chk("write_log_size", wr_addr.size(), w0 + 2);
        end

        b0 = n_beats;
        ed_mode = 2'b11; fill_buff = 1'b1;
        repeat (5) @(negedge clk);
        ed_mode = 2'b00; fill_buff = 1'b0;
        chk("reserved_mode_beats", n_beats - b0, 0);
        repeat (2) @(negedge clk);

        fill_start(20'd0, 0);
        for (int i = 0; i < 100 && (n_beats - b0) < 5; i++) @(negedge clk);
        chk("rst_mid_progress", (n_beats - b0) >= 5, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req, 1'b0);
        chk("rst_mid_rdata", rdata, 96'h0);
        chk("rst_mid_buff_filled", buff_filled, 1'b0);
        ed_mode = 2'b00; fill_buff = 1'b0; m_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        bf0 = n_bf;
        fill_start(20'd2, 0);
        fill_finish(bf0);
        chk("post_rst_lat", lat, 12);
        chk("post_rst_beats", beats, 12);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/edge_mem_ctrl.md
# edge_mem_ctrl

Memory sequencer for the Sobel edge-detection engine. It sits between the edge-detection module and the single byte-wide image SRAM port. On a fill request it fetches the 3×4-pixel window the engine needs and packs it into a 96-bit buffer. On a write request it stores the engine's two output pixels. It owns all address arithmetic from pixel indices to byte addresses.

## Interface
Parameters:
- ADDR_W, 24, memory byte-address width
- PIX_W, 20, pixel-index width

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; asynchronous, active-low
- ed_start  in  1  engine run enable; low invalidates retained window data
- ed_mode  in  2  engine mode: 00 idle, 01 fill, 10 write, 11 reserved (treated as idle)
- fill_buff  in  1  fill request, valid only with ed_mode=01
- rpixnum  in  PIX_W  top-left source pixel index of the window
- wpixnum  in  PIX_W  destination pixel index of the output pair
- wdata  in  16  output pixels: [7:0] goes to wpixnum, [15:8] goes to wpixnum+1
- image_width  in  12  source row length in pixels
- src_base, dst_base  in  ADDR_W  image byte base addresses; regions do not overlap
- buff_filled  out  1  one-cycle pulse: window valid
- rdata  out  96  window; byte k=row*4+col at [8k+7:8k]
- dfb  out  1  one-cycle pulse: both output bytes written
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid in the ack cycle
- mem_ack  in  1  beat completes in any cycle with mem_req && mem_ack

## Operation
- States:
  - IDLE: accepts a request.
  - RD: executes read beats.
  - WR: executes write beats.
  - RESP: pulses buff_filled or dfb.
  - HOLD: waits for ed_mode==00, then returns to IDLE. This blocks re-triggering on a stale mode.
- IDLE: ed_mode==01 && fill_buff goes to RD. ed_mode==10 goes to WR. Other values stay in IDLE. The two modes are mutually exclusive by encoding.
- Read addresses: row r, col c maps to src_base + rpixnum + r*image_width + c, with r in 0..2 and c in 0..3.
  - Beat order is row-major: r0c0..r0c3, r1c0..r1c3, r2c0..r2c3.
  - Each acked byte is written into its rdata slot.
- Write beats:
  - Beat 0: dst_base + wpixnum, data wdata[7:0].
  - Beat 1: +1, data wdata[15:8].
  - wdata and wpixnum are sampled on IDLE→WR.
- Address arithmetic:
  - Operands are zero-extended to ADDR_W; the sum is truncated to ADDR_W.
  - The row offset is computed as a running sum (add image_width per row). No multiplier.
- A request arriving while RD/WR/RESP/HOLD is active is ignored. Deasserting fill_buff mid-fetch does not abort the sequence.
- ed_start low in any state clears the reuse-valid flag (see Configuration). It does not abort an in-flight sequence.

## Timing
- Reset values:
  - State IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rdata=0, buff_filled=0, dfb=0.
  - Reuse flag cleared.
- Reset mid-beat drops mem_req immediately.
- All outputs are registered. A request sampled in IDLE at edge k drives mem_req from cycle k+1.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the ack cycle.
  - The next beat's request is presented in the following cycle with no idle gap.
- Zero-wait-state fill (ack in every request cycle):
  - 12 beats in cycles k+1..k+12.
  - buff_filled pulses at k+13.
  - rdata stays stable from k+13 until the next fill's first ack.
- Zero-wait write: beats in k+1..k+2; dfb pulses at k+3.
- Wait states extend each beat; pulse timing stays one cycle after the last ack.

## Configuration
- EDGE_COL_REUSE_EN defined:
  - The controller records the last filled rpixnum and sets the valid flag after each fill.
  - A fill with valid flag set and rpixnum == last+2 moves bytes c2,c3 into c0,c1 for each row.
  - It then fetches only c2,c3 per row: 6 beats, row-major, buff_filled at k+7.
  - Any other rpixnum triggers a full 12-beat fetch.
- EDGE_COL_REUSE_EN undefined: every fill is a full 12-beat fetch, and no last-index register or flag exists.

## Structure
- Package edge_ctrl_pkg holds:
  - The state enum.
  - Mode constants: ED_MODE_IDLE=2'b00, ED_MODE_FILL=2'b01, ED_MODE_WRITE=2'b10.
  - Beat-count constants: FULL_BEATS=12, REUSE_BEATS=6, WR_BEATS=2.
- Sub-module edge_addr_gen: holds the beat counter, row/col counters and the running row-base adder. It outputs the current mem_addr and the rdata slot index. The top-level FSM advances it on ack.

## Test plan
- Full fill: width=8, src_base=0x100, rpixnum=0, memory byte = address LSB, zero-wait acks → addresses 0x100–103, 0x108–10B, 0x110–113; rdata[7:0]=0x00, rdata[95:88]=0x13; buff_filled at k+13.
- Write: dst_base=0x4000, wpixnum=5, wdata=0xA532 → writes 0x32@0x4005, then 0xA5@0x4006; dfb at k+3; no new request until ed_mode returns to 00.
- Wait states: ack delayed 2 cycles per beat on a fill → mem_addr stable while unacked; buff_filled one cycle after the 12th ack.
- Reuse (macro on): fill rpixnum=0, then fill rpixnum=2 → 6 beats at 0x104/105, 0x10C/10D, 0x114/115. A fill with rpixnum=6, or one after ed_start dropped, fetches 12 beats.
- Reset: n_rst low during beat 5 of a fill → mem_req=0 at once, rdata=0, state IDLE; the next fill performs a full 12-beat fetch.
- Stale-mode guard: ed_mode held at 10 for 10 cycles after dfb → exactly 2 write beats and one dfb pulse.
